// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: register IDs, icodes and the scoreboard state type.
// Imported by the scoreboard and its per-register counter.
package y86_pkg;

  localparam logic [3:0] RRAX  = 4'h0;
  localparam logic [3:0] RRCX  = 4'h1;
  localparam logic [3:0] RRDX  = 4'h2;
  localparam logic [3:0] RRBX  = 4'h3;
  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RRBP  = 4'h5;
  localparam logic [3:0] RRSI  = 4'h6;
  localparam logic [3:0] RRDI  = 4'h7;
  localparam logic [3:0] RR8   = 4'h8;
  localparam logic [3:0] RR9   = 4'h9;
  localparam logic [3:0] RR10  = 4'hA;
  localparam logic [3:0] RR11  = 4'hB;
  localparam logic [3:0] RR12  = 4'hC;
  localparam logic [3:0] RR13  = 4'hD;
  localparam logic [3:0] RR14  = 4'hE;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } sb_state_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue handshake and write-back retirement bundle between decode,
// write-back and the register-file scoreboard.
interface regfile_scoreboard_if;
  import y86_pkg::*;

  logic       iss_valid;
  logic       iss_ready;
  logic [3:0] iss_srcA;
  logic [3:0] iss_srcB;
  logic [3:0] iss_dstE;
  logic [3:0] iss_dstM;
  logic       iss_halt;
  logic       wb_e_valid;
  logic [3:0] wb_e_reg;
  logic       wb_m_valid;
  logic [3:0] wb_m_reg;

  modport master (
    output iss_valid, iss_srcA, iss_srcB,
    output iss_dstE, iss_dstM, iss_halt,
    output wb_e_valid, wb_e_reg,
    output wb_m_valid, wb_m_reg,
    input  iss_ready
  );

  modport slave (
    input  iss_valid, iss_srcA, iss_srcB,
    input  iss_dstE, iss_dstM, iss_halt,
    input  wb_e_valid, wb_e_reg,
    input  wb_m_valid, wb_m_reg,
    output iss_ready
  );

endinterface

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register.
// Retirements apply before issues; the count floors at zero.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       inc,
  input  logic [1:0]       dec,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);
  import y86_pkg::*;

  localparam int W = CNT_W + 1;

  logic [W-1:0] ext;
  logic [W-1:0] dec_x;
  logic [W-1:0] inc_x;
  logic [W-1:0] eff;

  always_comb begin
    ext       = {1'b0, count};
    dec_x     = W'(dec);
    inc_x     = W'(inc);
    underflow = !clear && (dec_x > ext);
    eff       = (dec_x > ext) ? '0 : ext - dec_x;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= CNT_W'(eff + inc_x);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Issue-side hazard controller for the Y86-64 register file:
// per-register pending writes, issue gating, flush drain and halt.
module regfile_scoreboard
  import y86_pkg::*;
#(
  parameter int NUM_REGS = 15,
  parameter int CNT_W    = 2,
  parameter int STALL_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_scoreboard_if.slave bus,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                halted,
  output logic [STALL_W-1:0]  stall_cnt,
  output logic                err_underflow,
  output logic                err_ovf
);

  localparam int W = CNT_W + 1;
  localparam logic [W-1:0] LIMIT = W'((1 << CNT_W) - 1);

  sb_state_t state;

  logic [CNT_W-1:0]    cnt   [NUM_REGS];
  logic [1:0]          ret   [NUM_REGS];
  logic [1:0]          inc   [NUM_REGS];
  logic [W-1:0]        effv  [16];
  logic [NUM_REGS-1:0] uflow;

  logic run;
  logic src_clean;
  logic dual;
  logic room;
  logic fire;
  logic clear;

  // Entry 15 (RNONE) stays zero so unused operands read as clean.
  always_comb begin
    for (int r = 0; r < 16; r++) begin
      effv[r] = '0;
    end
    for (int r = 0; r < NUM_REGS; r++) begin
      ret[r] = {1'b0, bus.wb_e_valid && (bus.wb_e_reg == 4'(r))}
             + {1'b0, bus.wb_m_valid && (bus.wb_m_reg == 4'(r))};
      if (W'(ret[r]) > {1'b0, cnt[r]}) begin
        effv[r] = '0;
      end else begin
        effv[r] = {1'b0, cnt[r]} - W'(ret[r]);
      end
    end
  end

  always_comb begin
    run       = (state == RUN);
    src_clean = (effv[bus.iss_srcA] == '0)
             && (effv[bus.iss_srcB] == '0);
    dual      = (bus.iss_dstE == bus.iss_dstM)
             && (bus.iss_dstE != RNONE);
    if (dual) begin
      room = (effv[bus.iss_dstE] + W'(2)) <= LIMIT;
    end else begin
      room = ((bus.iss_dstE == RNONE)
             || ((effv[bus.iss_dstE] + W'(1)) <= LIMIT))
          && ((bus.iss_dstM == RNONE)
             || ((effv[bus.iss_dstM] + W'(1)) <= LIMIT));
    end
    bus.iss_ready = rst_n && run && !flush && src_clean && room;
    fire          = bus.iss_valid && bus.iss_ready;
    clear         = (run && flush) || (state == DRAIN);
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (fire) begin
        inc[r] = {1'b0, bus.iss_dstE == 4'(r)}
               + {1'b0, bus.iss_dstM == 4'(r)};
      end else begin
        inc[r] = 2'd0;
      end
      busy_mask[r] = (cnt[r] != '0);
    end
    halted = (state == HALTED);
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc[g]),
      .dec       (ret[g]),
      .clear     (clear),
      .count     (cnt[g]),
      .underflow (uflow[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN: begin
          if (flush) begin
            state <= DRAIN;
          end else if (fire && bus.iss_halt) begin
            state <= HALTED;
          end
        end
        DRAIN:   state <= flush ? DRAIN : RUN;
        HALTED:  state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt     <= '0;
      err_underflow <= 1'b0;
      err_ovf       <= 1'b0;
    end else begin
      if (bus.iss_valid && !bus.iss_ready && run
          && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + STALL_W'(1);
      end
      if (|uflow) begin
        err_underflow <= 1'b1;
      end
      if (bus.iss_valid && run && src_clean && !room) begin
        err_ovf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed checks of regfile_scoreboard against a
// behavioural pending-write model.
module tb_regfile_scoreboard;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [14:0] busy_mask;
  logic        halted;
  logic [15:0] stall_cnt;
  logic        err_underflow;
  logic        err_ovf;

  regfile_scoreboard_if bus ();

  regfile_scoreboard dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .flush         (flush),
    .busy_mask     (busy_mask),
    .halted        (halted),
    .stall_cnt     (stall_cnt),
    .err_underflow (err_underflow),
    .err_ovf       (err_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int mc [15];
  int mst;
  int mstall;
  bit meu;
  bit meo;
  bit last_ready;

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(bit v, int a, int b, int e, int m, bit h,
                       bit fl, bit ev, int er, bit mv, int mr);
    bus.iss_valid  = v;
    bus.iss_srcA   = 4'(a);
    bus.iss_srcB   = 4'(b);
    bus.iss_dstE   = 4'(e);
    bus.iss_dstM   = 4'(m);
    bus.iss_halt   = h;
    flush          = fl;
    bus.wb_e_valid = ev;
    bus.wb_e_reg   = 4'(er);
    bus.wb_m_valid = mv;
    bus.wb_m_reg   = 4'(mr);
  endtask

  task automatic model_reset();
    for (int r = 0; r < 15; r++) mc[r] = 0;
    mst = 0;
    mstall = 0;
    meu = 0;
    meo = 0;
  endtask

  // One clock: compare at the falling edge, advance the model, then
  // return 1 time unit after the rising edge.
  task automatic step();
    int ret [16];
    int eff [16];
    int a, b, e, m;
    bit clean, room, rdy, fire;
    logic [14:0] mask;
    @(negedge clk);
    for (int r = 0; r < 16; r++) begin
      ret[r] = 0;
      eff[r] = 0;
    end
    for (int r = 0; r < 15; r++) begin
      ret[r] = int'(bus.wb_e_valid && bus.wb_e_reg == 4'(r))
             + int'(bus.wb_m_valid && bus.wb_m_reg == 4'(r));
      eff[r] = (mc[r] > ret[r]) ? mc[r] - ret[r] : 0;
    end
    a = int'(bus.iss_srcA);
    b = int'(bus.iss_srcB);
    e = int'(bus.iss_dstE);
    m = int'(bus.iss_dstM);
    clean = (eff[a] == 0) && (eff[b] == 0);
    if (e != 15 && e == m) room = (eff[e] + 2 <= 3);
    else room = (e == 15 || eff[e] + 1 <= 3)
             && (m == 15 || eff[m] + 1 <= 3);
    rdy  = (mst == 0) && !flush && clean && room;
    fire = bus.iss_valid && rdy;
    mask = '0;
    for (int r = 0; r < 15; r++) mask[r] = (mc[r] != 0);
    chk("iss_ready", 32'(bus.iss_ready), 32'(rdy));
    chk("busy_mask", 32'(busy_mask), 32'(mask));
    chk("halted", 32'(halted), 32'(mst == 2));
    chk("stall_cnt", 32'(stall_cnt), 32'(mstall));
    chk("err_underflow", 32'(err_underflow), 32'(meu));
    chk("err_ovf", 32'(err_ovf), 32'(meo));
    last_ready = bus.iss_ready;
    if (mst == 0 && bus.iss_valid && !rdy && mstall < 65535) mstall++;
    if (mst == 0 && bus.iss_valid && clean && !room) meo = 1;
    if ((mst == 0 && flush) || mst == 1) begin
      for (int r = 0; r < 15; r++) mc[r] = 0;
      mst = flush ? 1 : 0;
    end else begin
      for (int r = 0; r < 15; r++) begin
        if (ret[r] > mc[r]) meu = 1;
        mc[r] = eff[r] + (fire ? int'(e == r) + int'(m == r) : 0);
      end
      if (mst == 0 && fire && bus.iss_halt) mst = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_ready"}, 32'(bus.iss_ready), 32'd0);
    chk({tag, "_busy"}, 32'(busy_mask), 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_stall"}, 32'(stall_cnt), 32'd0);
    chk({tag, "_uflow"}, 32'(err_underflow), 32'd0);
    chk({tag, "_ovf"}, 32'(err_ovf), 32'd0);
  endtask

  // Asserts reset away from any clock edge, checks outputs clear at once.
  task automatic do_reset(string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  int pend [$];
  int hold;
  int F = 15;

  initial begin
    model_reset();
    drive(1, F, F, F, F, 0, 0, 0, F, 0, F);
    #3;
    check_reset_outputs("rst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    drive(1, F, F, 3, F, 0, 0, 0, F, 0, F);
    step();
    chk("lit_busy3", 32'(busy_mask), 32'h8);
    chk("lit_mc3", 32'(mc[3]), 32'd1);

    drive(1, 3, F, F, F, 0, 0, 0, F, 0, F);
    step();
    step();
    step();
    chk("lit_stall3", 32'(stall_cnt), 32'd3);
    drive(1, 3, F, F, F, 0, 0, 1, 3, 0, F);
    step();
    chk("lit_unblock", 32'(last_ready), 32'd1);
    chk("lit_busy_clr", 32'(busy_mask), 32'h0);

    drive(1, F, F, 4, 4, 0, 0, 0, F, 0, F);
    step();
    chk("lit_mc4", 32'(mc[4]), 32'd2);
    chk("lit_busy4", 32'(busy_mask), 32'h10);
    drive(0, F, F, F, F, 0, 0, 1, 4, 1, 4);
    step();
    chk("lit_dual_ret", 32'(busy_mask), 32'h0);
    chk("lit_no_uflow", 32'(err_underflow), 32'd0);

    drive(1, F, F, 1, F, 0, 0, 0, F, 0, F);
    step();
    step();
    step();
    chk("lit_mc1", 32'(mc[1]), 32'd3);
    step();
    chk("lit_sat_block", 32'(last_ready), 32'd0);
    chk("lit_ovf", 32'(err_ovf), 32'd1);

    drive(1, F, F, 2, 5, 0, 0, 0, F, 0, F);
    step();
    chk("lit_busy25", 32'(busy_mask), 32'h26);
    drive(1, F, F, 6, F, 0, 1, 0, F, 0, F);
    step();
    chk("lit_flush_nofire", 32'(last_ready), 32'd0);
    drive(1, F, F, F, F, 0, 0, 0, F, 0, F);
    step();
    chk("lit_drain_rdy", 32'(last_ready), 32'd0);
    chk("lit_drain_busy", 32'(busy_mask), 32'h0);
    step();
    chk("lit_run_rdy", 32'(last_ready), 32'd1);

    drive(0, F, F, F, F, 0, 0, 1, 7, 0, F);
    step();
    chk("lit_uflow", 32'(err_underflow), 32'd1);
    chk("lit_busy7", 32'(busy_mask[7]), 32'd0);
    drive(0, F, F, F, F, 0, 0, 0, F, 0, F);
    step();
    chk("lit_uflow_sticky", 32'(err_underflow), 32'd1);

    drive(1, F, F, 9, F, 0, 0, 0, F, 0, F);
    step();
    drive(1, F, F, F, F, 1, 0, 0, F, 0, F);
    step();
    chk("lit_halted", 32'(halted), 32'd1);
    drive(1, F, F, F, F, 0, 0, 1, 9, 0, F);
    step();
    chk("lit_halt_rdy", 32'(last_ready), 32'd0);
    chk("lit_halt_ret", 32'(busy_mask), 32'h0);
    do_reset("arst");

    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      bit v, fl, ev, mv;
      int er, mr;
      if (mst == 2 && hold > 20) begin
        do_reset("rrst");
        hold = 0;
      end
      v  = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 49) == 0);
      pend.delete();
      for (int r = 0; r < 15; r++) if (mc[r] > 0) pend.push_back(r);
      ev = 0;
      mv = 0;
      er = F;
      mr = F;
      if (!fl && mst != 1) begin
        ev = ($urandom_range(0, 2) == 0);
        mv = ($urandom_range(0, 3) == 0);
        if (pend.size() > 0 && $urandom_range(0, 9) < 8) begin
          er = pend[$urandom_range(0, pend.size() - 1)];
          mr = pend[$urandom_range(0, pend.size() - 1)];
        end else begin
          er = $urandom_range(0, 15);
          mr = $urandom_range(0, 15);
        end
      end
      drive(v,
            ($urandom_range(0, 2) == 0) ? F : $urandom_range(0, 14),
            ($urandom_range(0, 2) == 0) ? F : $urandom_range(0, 14),
            ($urandom_range(0, 3) == 0) ? F : $urandom_range(0, 14),
            ($urandom_range(0, 2) == 0) ? F : $urandom_range(0, 14),
            ($urandom_range(0, 199) == 0), fl, ev, er, mv, mr);
      step();
      if (mst == 2) hold++;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Issue-side hazard controller for the 15-entry Y86-64 register file (IDs 0..14; 4'hF = RNONE).
- Tracks in-flight writes per register and grants issue only when both source registers are clean.
- Sequences pipeline drain on flush and halt.
- Sits between the decode stage and the register file: decode presents the operands of each instruction, and write-back reports each retirement here.

Parameters:
- NUM_REGS, 15, number of architectural registers tracked.
- CNT_W, 2, width of the per-register pending counter; saturation limit is 2^CNT_W-1 = 3.
- STALL_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  decode has an instruction to issue
- iss_ready  out  1  scoreboard accepts the issue this cycle
- iss_srcA  in  4  first source register, RNONE if unused
- iss_srcB  in  4  second source register, RNONE if unused
- iss_dstE  in  4  ALU destination register, RNONE if unused
- iss_dstM  in  4  memory destination register, RNONE if unused
- iss_halt  in  1  issuing instruction is halt (icode 0)
- flush  in  1  pipeline squash; all in-flight writes are cancelled
- wb_e_valid  in  1  valE write-back retiring this cycle
- wb_e_reg  in  4  register written by valE
- wb_m_valid  in  1  valM write-back retiring this cycle
- wb_m_reg  in  4  register written by valM
- busy_mask  out  15  bit r set when register r has a nonzero pending count
- halted  out  1  HALTED state indicator
- stall_cnt  out  STALL_W  saturating count of stalled cycles
- err_underflow  out  1  sticky flag: retirement on a clean register
- err_ovf  out  1  sticky flag: issue attempted with dst counter saturated while not otherwise blocked

Behaviour:
- Reset (async, rst_n=0):
  - all counters 0, state RUN, iss_ready 0 during reset
  - busy_mask 0, halted 0, stall_cnt 0, err flags 0
- Pending counters:
  - cnt[r], CNT_W bits, per register.
  - Effective count eff[r] = cnt[r] minus the number of same-cycle retirements to r (0, 1 or 2), floored at 0.
  - Retire-before-read: the register file writes before decode reads, so same-cycle retirement unblocks issue.
- iss_ready = (state==RUN) & !flush & srcA_clean & srcB_clean & dst_room.
  - src_clean: src==RNONE or eff[src]==0.
  - dst_room: each non-RNONE dst satisfies eff+inc <= 3. inc is 2 when dstE==dstM (popq %rsp style), else 1.
  - Purely combinational from inputs and registered state; no path from iss_ready back into inputs.
- fire = iss_valid & iss_ready.
- Next-state count: cnt'[r] = eff[r] + inc[r], where inc[r] counts fire-qualified dstE/dstM matches to r.
- Retire on a register whose cnt is 0 (or an over-retire of a double retirement):
  - count floors at 0
  - err_underflow set, sticky until reset
- Retire and wb ports naming RNONE are ignored.
- Both wb ports naming the same register decrement it by 2.
- State machine:
  - RUN: normal operation. flush → DRAIN. fire & iss_halt → HALTED (the halt itself is accepted).
  - DRAIN: all counters cleared; iss_ready 0 for exactly one cycle, then → RUN. flush again holds DRAIN.
  - HALTED: iss_ready 0; retirements still decrement; halted=1. Exit only via reset.
- Flush in RUN:
  - takes priority over a simultaneous fire
  - no increment occurs
  - counters are zeroed the next cycle; same-cycle retirements are discarded
- stall_cnt: +1 each cycle with iss_valid & !iss_ready & state==RUN; saturates at all-ones.
- err_ovf: set when iss_valid & state==RUN & sources clean & !dst_room.
- busy_mask: registered, consistent with cnt (cnt!=0) in the same cycle.

Decomposition:
- Shared package y86_pkg holds:
  - RNONE (4'hF) and register ID constants (RSP=4, ...)
  - icode constants (IHALT=0 ... IPOPQ=11)
  - sb_state_t enum {RUN, DRAIN, HALTED}
- One natural sub-module: sb_counter, a single-register pending counter. Inputs: inc (0..2), dec (0..2), clear. Outputs: count, underflow. Instantiated NUM_REGS times.

Test Plan:
- Reset, then issue dstE=3 with srcs RNONE → cnt[3]=1, busy_mask=0x0008. Next issue srcA=3 → iss_ready=0, stall_cnt increments until wb_e_reg=3; in the retirement cycle iss_ready=1 (same-cycle unblock).
- Issue dstE=4, dstM=4 (popq %rsp) → cnt[4]=2. wb_e and wb_m both to reg 4 in one cycle → cnt[4]=0, no err_underflow.
- Three issues with dstE=1 → cnt[1]=3. Fourth issue with dstE=1 → iss_ready=0, err_ovf=1.
- Pending on regs 2 and 5, assert flush with iss_valid=1 → no fire. Next cycle DRAIN: busy_mask=0, iss_ready=0. Cycle after: RUN, iss_ready=1.
- wb_e_reg=7 with cnt[7]=0 → err_underflow=1 and stays set; cnt[7] remains 0.
- Issue halt (iss_halt=1) → halted=1, iss_ready=0 permanently. Outstanding retirements still clear busy_mask. Drop rst_n mid-stream → all outputs return to reset values asynchronously.
